// File: rtl/cpu_csr_pkg.sv
// Shared definitions for the Zicsr execute-stage sequencer and the CSR
// register file: CSR address map, funct3 encodings, sequencer state type and
// the helper functions that classify addresses and compute the new CSR value.
package cpu_csr_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;

    // Implemented CSR addresses (user counters and supervisor set)
    localparam logic [ADDR_W-1:0] CSR_CYCLE    = 12'hC00;
    localparam logic [ADDR_W-1:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [ADDR_W-1:0] CSR_TIME     = 12'hC01;
    localparam logic [ADDR_W-1:0] CSR_TIMEH    = 12'hC81;
    localparam logic [ADDR_W-1:0] CSR_INSTRET  = 12'hC02;
    localparam logic [ADDR_W-1:0] CSR_INSTRETH = 12'hC82;
    localparam logic [ADDR_W-1:0] CSR_SSTATUS  = 12'h100;
    localparam logic [ADDR_W-1:0] CSR_SIE      = 12'h104;
    localparam logic [ADDR_W-1:0] CSR_STVEC    = 12'h105;
    localparam logic [ADDR_W-1:0] CSR_SSCRATCH = 12'h140;
    localparam logic [ADDR_W-1:0] CSR_SEPC     = 12'h141;
    localparam logic [ADDR_W-1:0] CSR_SCAUSE   = 12'h142;
    localparam logic [ADDR_W-1:0] CSR_STVAL    = 12'h143;
    localparam logic [ADDR_W-1:0] CSR_SIP      = 12'h144;

    // funct3 encodings; bit 2 selects the zimm operand
    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } csr_state_t;

    // True when the address names a CSR that exists in this core
    function automatic logic csr_implemented(input logic [ADDR_W-1:0] addr);
        case (addr)
            CSR_CYCLE, CSR_CYCLEH, CSR_TIME, CSR_TIMEH, CSR_INSTRET,
            CSR_INSTRETH, CSR_SSTATUS, CSR_SIE, CSR_STVEC, CSR_SSCRATCH,
            CSR_SEPC, CSR_SCAUSE, CSR_STVAL, CSR_SIP:
                csr_implemented = 1'b1;
            default:
                csr_implemented = 1'b0;
        endcase
    endfunction

    // The top two address bits both set mark the read-only CSR space
    function automatic logic csr_read_only(input logic [ADDR_W-1:0] addr);
        csr_read_only = (addr[11:10] == 2'b11);
    endfunction

    // New CSR value for the read-modify-write: write, set bits or clear bits
    function automatic logic [DATA_W-1:0] csr_rmw(input logic [2:0]        funct3,
                                                  input logic [DATA_W-1:0] old_val,
                                                  input logic [DATA_W-1:0] op);
        case (funct3)
            F3_RW, F3_RWI: csr_rmw = op;
            F3_RS, F3_RSI: csr_rmw = old_val | op;
            F3_RC, F3_RCI: csr_rmw = old_val & ~op;
            default:       csr_rmw = old_val;
        endcase
    endfunction

endpackage

// File: rtl/cpu_csr_unit.sv
// Execute-stage sequencer for Zicsr instructions. Accepts one CSR instruction
// per start pulse, reads the CSR file, computes the new value, optionally
// writes it back, and returns the old value for rd with a one-cycle done pulse.
// Illegal accesses skip the CSR file entirely and report illegal with done.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               request pulse, taken only while busy is low
//   funct3, csr_addr    instruction fields
//   rs1_idx, rs1_val    rs1 field (also zimm) and rs1 register value
//   busy, done          sequencer status, one-cycle completion pulse
//   illegal, rd_val     trap flag and old CSR value, valid with done
//   csr_addr_o          CSR file address
//   csr_rdata           CSR file combinational read data
//   csr_wdata, csr_wr   CSR file write data and write strobe
module cpu_csr_unit
    import cpu_csr_pkg::*;
#(
    parameter int XLEN       = DATA_W,
    parameter int CSR_ADDR_W = ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [CSR_ADDR_W-1:0] csr_addr,
    input  logic [4:0]            rs1_idx,
    input  logic [XLEN-1:0]       rs1_val,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic [XLEN-1:0]       rd_val,
    output logic [CSR_ADDR_W-1:0] csr_addr_o,
    input  logic [XLEN-1:0]       csr_rdata,
    output logic [XLEN-1:0]       csr_wdata,
    output logic                  csr_wr
);

    csr_state_t  state;
    logic [2:0]  f3_q;
    logic [XLEN-1:0] op_q;
    logic        wr_req_q;

    logic [XLEN-1:0] start_op;
    logic        start_wr_req;
    logic        start_illegal;

    // Decode the incoming instruction: pick rs1 value or zero-extended zimm,
    // decide whether a write is architecturally requested (set/clear with a
    // zero rs1 field never writes), and classify the access as legal or not.
    always_comb begin
        start_op      = rs1_val;
        start_wr_req  = 1'b0;
        start_illegal = 1'b0;
        if (funct3[2]) begin
            start_op = {{(XLEN-5){1'b0}}, rs1_idx};
        end
        if (funct3[1:0] == 2'b01) begin
            start_wr_req = 1'b1;
        end else begin
            start_wr_req = (rs1_idx != 5'd0);
        end
        if (funct3[1:0] == 2'b00) begin
            start_illegal = 1'b1;
        end else if (!csr_implemented(csr_addr)) begin
            start_illegal = 1'b1;
        end else if (start_wr_req && csr_read_only(csr_addr)) begin
            start_illegal = 1'b1;
        end
    end

    // Sequencer: every output is a register so the CSR file sees clean
    // address/data/strobe, and reset drops the strobe and done immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            f3_q       <= 3'b000;
            op_q       <= '0;
            wr_req_q   <= 1'b0;
            csr_addr_o <= '0;
            rd_val     <= '0;
            csr_wdata  <= '0;
            illegal    <= 1'b0;
            done       <= 1'b0;
            csr_wr     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done   <= 1'b0;
            csr_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        f3_q       <= funct3;
                        op_q       <= start_op;
                        wr_req_q   <= start_wr_req;
                        csr_addr_o <= csr_addr;
                        busy       <= 1'b1;
                        if (start_illegal) begin
                            illegal <= 1'b1;
                            rd_val  <= '0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            illegal <= 1'b0;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    rd_val    <= csr_rdata;
                    csr_wdata <= csr_rmw(f3_q, csr_rdata, op_q);
                    if (wr_req_q) begin
                        csr_wr <= 1'b1;
                        state  <= WRITE;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WRITE: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Self-checking bench for cpu_csr_unit: a table of CSR instructions with
// hand-computed results driven through a scoreboard, plus hand-written
// sequences for reset during a write and a start held across an operation.
module tb_cpu_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_val;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [31:0] rd_val;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_rdata;
    logic [31:0] csr_wdata;
    logic        csr_wr;

    logic [31:0] rdata_fixed;
    logic        use_counter;
    int          cycle_cnt = 0;
    int          cnt_offset;

    int n_applied     = 0;
    int n_checks      = 0;
    int n_miscompares = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] rs1;
        logic [31:0] rdata;
        logic        cnt;
        logic [31:0] exp_rd;
        logic        exp_ill;
        int          exp_lat;
        logic        exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        ill;
        int          lat;
        logic        wr;
        logic [31:0] wdata;
        logic [11:0] addr;
    } exp_t;

    typedef struct {
        int          done_cyc;
        logic        ill;
        logic [31:0] rd;
        int          wr_cnt;
        int          wr_cyc;
        logic [31:0] wdata;
        logic [11:0] waddr;
        logic [11:0] raddr;
        logic        idle_after;
    } obs_t;

    exp_t scoreboard[$];
    vec_t vecs[14];

    cpu_csr_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .funct3     (funct3),
        .csr_addr   (csr_addr),
        .rs1_idx    (rs1_idx),
        .rs1_val    (rs1_val),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .rd_val     (rd_val),
        .csr_addr_o (csr_addr_o),
        .csr_rdata  (csr_rdata),
        .csr_wdata  (csr_wdata),
        .csr_wr     (csr_wr)
    );

    // Clock and a free-running cycle counter that stands in for mcycle
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // CSR file read port: a fixed value, or the running counter
    assign csr_rdata = use_counter ? 32'(cycle_cnt - cnt_offset) : rdata_fixed;

    // Hard time limit so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one instruction, record the expectation, then watch the DUT until
    // done (bounded) and collect what it did on the CSR file interface.
    task automatic applyStimulus(input vec_t v, output obs_t o);
        exp_t e;
        @(negedge clk);
        funct3      = v.f3;
        csr_addr    = v.addr;
        rs1_idx     = v.idx;
        rs1_val     = v.rs1;
        rdata_fixed = v.rdata;
        use_counter = v.cnt;
        cnt_offset  = cycle_cnt + 1 - 57;
        start       = 1'b1;
        n_applied++;
        e.name  = v.name;
        e.rd    = v.exp_rd;
        e.ill   = v.exp_ill;
        e.lat   = v.exp_lat;
        e.wr    = v.exp_wr;
        e.wdata = v.exp_wdata;
        e.addr  = v.addr;
        scoreboard.push_back(e);
        o.done_cyc   = -1;
        o.ill        = 1'bx;
        o.rd         = 'x;
        o.wr_cnt     = 0;
        o.wr_cyc     = -1;
        o.wdata      = 'x;
        o.waddr      = 'x;
        o.raddr      = 'x;
        o.idle_after = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start   = 1'b0;
                o.raddr = csr_addr_o;
            end
            if (csr_wr) begin
                o.wr_cnt++;
                o.wr_cyc = k;
                o.wdata  = csr_wdata;
                o.waddr  = csr_addr_o;
            end
            if (done) begin
                o.done_cyc = k;
                o.ill      = illegal;
                o.rd       = rd_val;
                break;
            end
        end
        @(negedge clk);
        o.idle_after = !busy && !done;
    endtask

    // Pop the oldest expectation and compare it against what was observed
    task automatic checkOutput(input obs_t o);
        exp_t e;
        if (scoreboard.size() == 0) begin
            n_checks++;
            n_miscompares++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = scoreboard.pop_front();
        check({e.name, "_latency"}, 32'(o.done_cyc), 32'(e.lat));
        check({e.name, "_illegal"}, {31'b0, o.ill}, {31'b0, e.ill});
        check({e.name, "_rd_val"}, o.rd, e.rd);
        check({e.name, "_wr_count"}, 32'(o.wr_cnt), e.wr ? 32'd1 : 32'd0);
        if (e.wr) begin
            check({e.name, "_wr_cycle"}, 32'(o.wr_cyc), 32'd2);
            check({e.name, "_wdata"}, o.wdata, e.wdata);
            check({e.name, "_wr_addr"}, {20'b0, o.waddr}, {20'b0, e.addr});
        end
        if (!e.ill) begin
            check({e.name, "_read_addr"}, {20'b0, o.raddr}, {20'b0, e.addr});
        end
        check({e.name, "_idle_after"}, {31'b0, o.idle_after}, 32'd1);
    endtask

    initial begin
        obs_t o;
        int   dones;
        int   wrs;
        logic b4;
        logic b5;
        int   second_done;

        vecs[0]  = '{"rw_sepc",       3'b001, 12'h141, 5'd5,  32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0, 3, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{"rs_sstatus",    3'b010, 12'h100, 5'd3,  32'h0000_0022, 32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0, 3, 1'b1, 32'h0000_0122};
        vecs[2]  = '{"rc_sstatus",    3'b011, 12'h100, 5'd3,  32'h0000_0022, 32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0, 3, 1'b1, 32'h0000_0100};
        vecs[3]  = '{"rs_cycle_x0",   3'b010, 12'hC00, 5'd0,  32'hFFFF_FFFF, 32'h0,         1'b1, 32'd57,        1'b0, 2, 1'b0, 32'h0};
        vecs[4]  = '{"rwi_time_ro",   3'b101, 12'hC01, 5'd7,  32'h0,         32'h5555_5555, 1'b0, 32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[5]  = '{"f3_100",        3'b100, 12'h141, 5'd4,  32'h1,         32'h7777_7777, 1'b0, 32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[6]  = '{"rw_unimpl",     3'b001, 12'h7C0, 5'd2,  32'h1,         32'h6666_6666, 1'b0, 32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[7]  = '{"rsi_sip",       3'b110, 12'h144, 5'h0A, 32'hFFFF_FFFF, 32'h0000_00F0, 1'b0, 32'h0000_00F0, 1'b0, 3, 1'b1, 32'h0000_00FA};
        vecs[8]  = '{"rci_scause",    3'b111, 12'h142, 5'h03, 32'h0,         32'h0000_00FF, 1'b0, 32'h0000_00FF, 1'b0, 3, 1'b1, 32'h0000_00FC};
        vecs[9]  = '{"rsi_cycleh_x0", 3'b110, 12'hC80, 5'd0,  32'h0,         32'h0000_ABCD, 1'b0, 32'h0000_ABCD, 1'b0, 2, 1'b0, 32'h0};
        vecs[10] = '{"rs_instret_ro", 3'b010, 12'hC02, 5'd1,  32'h1,         32'h1111_1111, 1'b0, 32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[11] = '{"f3_000",        3'b000, 12'h100, 5'd1,  32'h1,         32'h2222_2222, 1'b0, 32'h0,         1'b1, 1, 1'b0, 32'h0};
        vecs[12] = '{"rwi_stvec",     3'b101, 12'h105, 5'd31, 32'h0,         32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0, 3, 1'b1, 32'h0000_001F};
        vecs[13] = '{"rc_stval_x0",   3'b011, 12'h143, 5'd0,  32'hFFFF_FFFF, 32'h0000_0055, 1'b0, 32'h0000_0055, 1'b0, 2, 1'b0, 32'h0};

        rst         = 1'b1;
        start       = 1'b0;
        funct3      = 3'b000;
        csr_addr    = 12'h000;
        rs1_idx     = 5'd0;
        rs1_val     = 32'h0;
        rdata_fixed = 32'h0;
        use_counter = 1'b0;
        cnt_offset  = 0;
        $display("[TB] reset phase");
        repeat (2) @(negedge clk);
        check("reset_busy",       {31'b0, busy},    32'd0);
        check("reset_done",       {31'b0, done},    32'd0);
        check("reset_illegal",    {31'b0, illegal}, 32'd0);
        check("reset_csr_wr",     {31'b0, csr_wr},  32'd0);
        check("reset_rd_val",     rd_val,           32'd0);
        check("reset_csr_wdata",  csr_wdata,        32'd0);
        check("reset_csr_addr_o", {20'b0, csr_addr_o}, 32'd0);
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], o);
            checkOutput(o);
        end

        // Reset asserted while the write strobe is high
        $display("[TB] reset during write");
        @(negedge clk);
        funct3      = 3'b001;
        csr_addr    = 12'h140;
        rs1_idx     = 5'd9;
        rs1_val     = 32'hCAFE_F00D;
        rdata_fixed = 32'h0000_0042;
        use_counter = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_wr_before_rst", {31'b0, csr_wr}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_wr_async_drop", {31'b0, csr_wr}, 32'd0);
        check("abort_busy",          {31'b0, busy},   32'd0);
        check("abort_done",          {31'b0, done},   32'd0);
        check("abort_rd_val",        rd_val,          32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        applyStimulus(vecs[0], o);
        checkOutput(o);

        // start held for five cycles: one op, then a second accepted after done
        $display("[TB] start held across an operation");
        @(negedge clk);
        funct3      = 3'b001;
        csr_addr    = 12'h141;
        rs1_idx     = 5'd6;
        rs1_val     = 32'hA5A5_A5A5;
        rdata_fixed = 32'h0000_0011;
        use_counter = 1'b0;
        start       = 1'b1;
        dones       = 0;
        wrs         = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (csr_wr) wrs++;
        end
        @(negedge clk);
        b4 = busy;
        if (done) dones++;
        if (csr_wr) wrs++;
        @(negedge clk);
        start = 1'b0;
        b5 = busy;
        check("hold_first_dones",    32'(dones), 32'd1);
        check("hold_first_writes",   32'(wrs),   32'd1);
        check("hold_idle_after_done", {31'b0, b4}, 32'd0);
        check("hold_second_accepted", {31'b0, b5}, 32'd1);
        second_done = -1;
        for (int k = 6; k <= 12; k++) begin
            @(negedge clk);
            if (csr_wr) wrs++;
            if (done) begin
                second_done = k;
                break;
            end
        end
        check("hold_second_done_cycle", 32'(second_done), 32'd7);
        check("hold_total_writes",      32'(wrs),         32'd2);
        check("hold_second_rd_val",     rd_val,           32'h0000_0011);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
